tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine that sequences the JTAG TDO output logic and the data/instruction shift registers.
- Decodes TMS on each TCK edge into one of 16 TAP states.
- Drives the dr_shift / ir_shift / tlr_reset controls consumed by the output logic, plus capture/update strobes for the IR and DR chains.
- Adds a saturating shift-bit counter and a TDO-enable flag so the bench and the AHB access path can check shift lengths.

Parameters:
- CNT_W, 16, width of shift_count; counter saturates at 2^CNT_W-1.

Ports:
- TCK  input  1  sole clock; all state updates on rising edge.
- TRST  input  1  synchronous, active-high reset; forces Test-Logic-Reset.
- TMS  input  1  test mode select, sampled on TCK rising edge.
- tap_state  output  4  current state, tap_state_t encoding.
- tlr_reset  output  1  high while in Test-Logic-Reset.
- capture_dr  output  1  high in Capture-DR.
- dr_shift  output  1  high in Shift-DR.
- update_dr  output  1  high in Update-DR.
- capture_ir  output  1  high in Capture-IR.
- ir_shift  output  1  high in Shift-IR.
- update_ir  output  1  high in Update-IR.
- tdo_en  output  1  registered; high in the cycle after the FSM is in Shift-DR or Shift-IR.
- shift_count  output  CNT_W  number of shift cycles since the last Capture-DR/IR.

Behaviour:
- State register only; all strobes are Moore-decoded combinationally from the registered state. Each strobe is high exactly for the TCK cycles the state is held.
- Encoding (tap_state_t, 4 bits):
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPDATE_DR=5
  - SEL_IR=4, CAP_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPDATE_IR=D
- Transitions (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SHIFT_DR / EXIT1_DR
  - SHIFT_DR: SHIFT_DR / EXIT1_DR
  - EXIT1_DR: PAUSE_DR / UPDATE_DR
  - PAUSE_DR: PAUSE_DR / EXIT2_DR
  - EXIT2_DR: SHIFT_DR / UPDATE_DR
  - UPDATE_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR branch mirrors the DR branch; UPDATE_IR: RTI / SEL_DR
- Reset values (TRST=1 at a rising edge):
  - tap_state=TLR, so tlr_reset=1.
  - All other strobes 0, tdo_en=0, shift_count=0.
  - TRST has priority over TMS in every state, including mid-shift; no update strobe is generated on abort.
- Five consecutive TMS=1 edges from any state reach TLR. This falls out of the transition table; no separate counter.
- shift_count:
  - Cleared to 0 on the edge entering CAP_DR or CAP_IR.
  - Increments by 1 on each edge where the current state is SHIFT_DR or SHIFT_IR.
  - Holds in all other states, so Pause/Exit2 re-entry continues the count.
  - Saturates at all-ones and never wraps.
- tdo_en:
  - Registered: next value = (state==SHIFT_DR || state==SHIFT_IR).
  - Lags the shift flags by one cycle, matching output logic that drives TDO from registered data.
- No combinational path from TMS to any output.

Decomposition:
- tap_state_t enum, with the explicit 4-bit codes above, is added to jtag_types_pkg alongside instruction_t.
- No sub-module: next-state logic, output decode and counter fit in one ~150-line module.
- Strobe decode may be a function in the package so the output-logic bench can reuse it.

Test Plan:
- TRST=1 one edge, TMS=0 → tap_state=F, tlr_reset=1, all other strobes 0, shift_count=0; next edge → tap_state=C.
- From RTI, TMS=1,0,0 → SEL_DR, CAP_DR (capture_dr=1 one cycle), SHIFT_DR (dr_shift=1).
  - Hold TMS=0 for 8 edges → shift_count=8, tdo_en=1 from the second Shift-DR cycle.
- From RTI, TMS=1,1,0,0, then TMS=0 x32, then TMS=1,1 → traverses SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPDATE_IR.
  - ir_shift high for 33 cycles; shift_count ends at 33.
  - update_ir high exactly one cycle; tdo_en drops one cycle after leaving SHIFT_IR.
- Shift-DR 3 bits, TMS=1,0 (PAUSE_DR) x4, TMS=1,0 (EXIT2_DR→SHIFT_DR), shift 2 more → shift_count=6, unchanged during Pause.
- From SHIFT_IR, TMS=1 x5 → EXIT1_IR, UPDATE_IR, SEL_DR, SEL_IR, TLR; tlr_reset=1 after the fifth edge.
- Mid-Shift-DR with shift_count=5, TRST=1 → next state TLR, shift_count=0, update_dr never asserted.
- CNT_W=4, shift 20 cycles → shift_count saturates at 15.

Source files
------------

// File: rtl/tap_controller_pkg.sv
// Shared JTAG TAP types: state encoding, strobe bundle and the Moore strobe decode
// so other JTAG blocks and benches can reuse the exact same decode.
package tap_controller_pkg;

    typedef enum logic [3:0] {
        TLR       = 4'hF,
        RTI       = 4'hC,
        SEL_DR    = 4'h7,
        CAP_DR    = 4'h6,
        SHIFT_DR  = 4'h2,
        EXIT1_DR  = 4'h1,
        PAUSE_DR  = 4'h3,
        EXIT2_DR  = 4'h0,
        UPDATE_DR = 4'h5,
        SEL_IR    = 4'h4,
        CAP_IR    = 4'hE,
        SHIFT_IR  = 4'hA,
        EXIT1_IR  = 4'h9,
        PAUSE_IR  = 4'hB,
        EXIT2_IR  = 4'h8,
        UPDATE_IR = 4'hD
    } tap_state_t;

    typedef enum logic [3:0] {
        INSTR_EXTEST = 4'h0,
        INSTR_IDCODE = 4'h1,
        INSTR_BYPASS = 4'hF
    } instruction_t;

    typedef struct packed {
        logic tlr_reset;
        logic capture_dr;
        logic dr_shift;
        logic update_dr;
        logic capture_ir;
        logic ir_shift;
        logic update_ir;
    } tap_strobes_t;

    function automatic tap_strobes_t decode_strobes(input tap_state_t st);
        tap_strobes_t s;
        s.tlr_reset  = (st == TLR);
        s.capture_dr = (st == CAP_DR);
        s.dr_shift   = (st == SHIFT_DR);
        s.update_dr  = (st == UPDATE_DR);
        s.capture_ir = (st == CAP_IR);
        s.ir_shift   = (st == SHIFT_IR);
        s.update_ir  = (st == UPDATE_IR);
        return s;
    endfunction

    function automatic logic is_shift_state(input tap_state_t st);
        return (st == SHIFT_DR) || (st == SHIFT_IR);
    endfunction

    function automatic logic is_capture_state(input tap_state_t st);
        return (st == CAP_DR) || (st == CAP_IR);
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP control bundle: TMS in, decoded state/strobes and shift bookkeeping out.
interface tap_controller_if #(parameter int CNT_W = 16);
    import tap_controller_pkg::*;

    logic             TMS;
    tap_state_t       tap_state;
    logic             tlr_reset;
    logic             capture_dr;
    logic             dr_shift;
    logic             update_dr;
    logic             capture_ir;
    logic             ir_shift;
    logic             update_ir;
    logic             tdo_en;
    logic [CNT_W-1:0] shift_count;

    modport master (
        input  TMS,
        output tap_state, tlr_reset, capture_dr, dr_shift, update_dr,
               capture_ir, ir_shift, update_ir, tdo_en, shift_count
    );

    modport slave (
        output TMS,
        input  tap_state, tlr_reset, capture_dr, dr_shift, update_dr,
               capture_ir, ir_shift, update_ir, tdo_en, shift_count
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with Moore strobes, a registered TDO enable
// and a saturating count of shift cycles since the last capture.
module tap_controller
    import tap_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              TCK,
    input  logic              TRST,
    tap_controller_if.master  tap
);

    tap_state_t       state_r;
    tap_state_t       next_state_s;
    tap_strobes_t     strobes_s;
    logic             tdo_en_r;
    logic [CNT_W-1:0] shift_count_r;
    logic             count_sat_s;

    // State register; TRST overrides TMS from every state.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_r <= TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode from the current state and TMS.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            TLR:       next_state_s = tap.TMS ? TLR       : RTI;
            RTI:       next_state_s = tap.TMS ? SEL_DR    : RTI;
            SEL_DR:    next_state_s = tap.TMS ? SEL_IR    : CAP_DR;
            CAP_DR:    next_state_s = tap.TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  next_state_s = tap.TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  next_state_s = tap.TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  next_state_s = tap.TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  next_state_s = tap.TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: next_state_s = tap.TMS ? SEL_DR    : RTI;
            SEL_IR:    next_state_s = tap.TMS ? TLR       : CAP_IR;
            CAP_IR:    next_state_s = tap.TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  next_state_s = tap.TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  next_state_s = tap.TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  next_state_s = tap.TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  next_state_s = tap.TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: next_state_s = tap.TMS ? SEL_DR    : RTI;
            default:   next_state_s = TLR;
        endcase
    end

    assign count_sat_s = &shift_count_r;

    // Shift counter: cleared entering capture, counts shift edges, holds elsewhere, never wraps.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            shift_count_r <= {CNT_W{1'b0}};
        end else if (is_capture_state(next_state_s)) begin
            shift_count_r <= {CNT_W{1'b0}};
        end else if (is_shift_state(state_r) && !count_sat_s) begin
            shift_count_r <= shift_count_r + CNT_W'(1);
        end else begin
            shift_count_r <= shift_count_r;
        end
    end

    // TDO enable trails the shift states by one TCK, matching registered TDO data.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            tdo_en_r <= 1'b0;
        end else begin
            tdo_en_r <= is_shift_state(state_r);
        end
    end

    // Moore decode of the strobes from the registered state only.
    always_comb begin
        strobes_s = decode_strobes(state_r);
    end

    assign tap.tap_state   = state_r;
    assign tap.tlr_reset   = strobes_s.tlr_reset;
    assign tap.capture_dr  = strobes_s.capture_dr;
    assign tap.dr_shift    = strobes_s.dr_shift;
    assign tap.update_dr   = strobes_s.update_dr;
    assign tap.capture_ir  = strobes_s.capture_ir;
    assign tap.ir_shift    = strobes_s.ir_shift;
    assign tap.update_ir   = strobes_s.update_ir;
    assign tap.tdo_en      = tdo_en_r;
    assign tap.shift_count = shift_count_r;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: vector table, directed corner sequences
// and random TMS/TRST traffic against a table-driven TAP model, on 16- and 4-bit counters.
module tb_tap_controller;
    import tap_controller_pkg::*;

    logic tck;
    logic trst;
    int   checks;
    int   errors;

    tap_controller_if #(.CNT_W(16)) bus16 ();
    tap_controller_if #(.CNT_W(4))  bus4 ();

    tap_controller #(.CNT_W(16)) dut16 (.TCK(tck), .TRST(trst), .tap(bus16.master));
    tap_controller #(.CNT_W(4))  dut4  (.TCK(tck), .TRST(trst), .tap(bus4.master));

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Reference model: transition table straight from the 1149.1 state diagram.
    logic [3:0] nxt_tbl [16][2];
    logic [3:0] m_state;
    int         m_cnt16;
    int         m_cnt4;
    bit         m_tdo;
    int         ir_shift_cycles;
    int         update_ir_cycles;
    int         update_dr_cycles;

    function automatic void set_tr(input logic [3:0] s, input logic [3:0] t0, input logic [3:0] t1);
        nxt_tbl[s][0] = t0;
        nxt_tbl[s][1] = t1;
    endfunction

    function automatic void init_table();
        set_tr(4'hF, 4'hC, 4'hF);  set_tr(4'hC, 4'hC, 4'h7);
        set_tr(4'h7, 4'h6, 4'h4);  set_tr(4'h6, 4'h2, 4'h1);
        set_tr(4'h2, 4'h2, 4'h1);  set_tr(4'h1, 4'h3, 4'h5);
        set_tr(4'h3, 4'h3, 4'h0);  set_tr(4'h0, 4'h2, 4'h5);
        set_tr(4'h5, 4'hC, 4'h7);  set_tr(4'h4, 4'hE, 4'hF);
        set_tr(4'hE, 4'hA, 4'h9);  set_tr(4'hA, 4'hA, 4'h9);
        set_tr(4'h9, 4'hB, 4'hD);  set_tr(4'hB, 4'hB, 4'h8);
        set_tr(4'h8, 4'hA, 4'hD);  set_tr(4'hD, 4'hC, 4'h7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int width);
        int maxv;
        maxv = (1 << width) - 1;
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // One TCK: drive at the falling edge, advance the model, compare just after the rising edge.
    task automatic step(input bit tms, input bit rst);
        bit was_shift;
        @(negedge tck);
        bus16.TMS = tms;
        bus4.TMS  = tms;
        trst      = rst;
        @(posedge tck);
        if (rst) begin
            m_state = 4'hF; m_cnt16 = 0; m_cnt4 = 0; m_tdo = 1'b0;
        end else begin
            was_shift = (m_state == 4'h2) || (m_state == 4'hA);
            m_tdo     = was_shift;
            m_state   = nxt_tbl[m_state][tms];
            if (m_state == 4'h6 || m_state == 4'hE) begin
                m_cnt16 = 0; m_cnt4 = 0;
            end else if (was_shift) begin
                m_cnt16 = sat_inc(m_cnt16, 16);
                m_cnt4  = sat_inc(m_cnt4, 4);
            end
        end
        #1;
        chk("state",       32'(bus16.tap_state),   32'(m_state));
        chk("tlr_reset",   32'(bus16.tlr_reset),   32'(m_state == 4'hF));
        chk("capture_dr",  32'(bus16.capture_dr),  32'(m_state == 4'h6));
        chk("dr_shift",    32'(bus16.dr_shift),    32'(m_state == 4'h2));
        chk("update_dr",   32'(bus16.update_dr),   32'(m_state == 4'h5));
        chk("capture_ir",  32'(bus16.capture_ir),  32'(m_state == 4'hE));
        chk("ir_shift",    32'(bus16.ir_shift),    32'(m_state == 4'hA));
        chk("update_ir",   32'(bus16.update_ir),   32'(m_state == 4'hD));
        chk("tdo_en",      32'(bus16.tdo_en),      32'(m_tdo));
        chk("shift_count", 32'(bus16.shift_count), 32'(m_cnt16));
        chk("state_w4",    32'(bus4.tap_state),    32'(m_state));
        chk("tdo_en_w4",   32'(bus4.tdo_en),       32'(m_tdo));
        chk("count_w4",    32'(bus4.shift_count),  32'(m_cnt4));
        if (bus16.ir_shift === 1'b1)  ir_shift_cycles++;
        if (bus16.update_ir === 1'b1) update_ir_cycles++;
        if (bus16.update_dr === 1'b1) update_dr_cycles++;
    endtask

    typedef struct {
        bit         tms;
        bit         trst;
        logic [3:0] st;
        int         cnt;
        bit         tdo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit tms, input bit rst, input logic [3:0] st, input int cnt, input bit tdo);
        vec_t v;
        v.tms = tms; v.trst = rst; v.st = st; v.cnt = cnt; v.tdo = tdo;
        return v;
    endfunction

    initial begin
        checks = 0; errors = 0;
        trst = 1'b1; bus16.TMS = 1'b0; bus4.TMS = 1'b0;
        m_state = 4'hF; m_cnt16 = 0; m_cnt4 = 0; m_tdo = 1'b0;
        ir_shift_cycles = 0; update_ir_cycles = 0; update_dr_cycles = 0;
        init_table();

        // Reset, RTI, then into Shift-DR and eight shift edges.
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'hC, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h7, 0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h6, 0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h2, 0, 1'b0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b0, 1'b0, 4'h2, i, 1'b1));
        foreach (vecs[i]) begin
            step(vecs[i].tms, vecs[i].trst);
            chk("vec_state", 32'(bus16.tap_state),   32'(vecs[i].st));
            chk("vec_count", 32'(bus16.shift_count), 32'(vecs[i].cnt));
            chk("vec_tdo",   32'(bus16.tdo_en),      32'(vecs[i].tdo));
        end

        // Back to RTI, then a 33-cycle IR scan ending in Update-IR.
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("rti_before_ir", 32'(bus16.tap_state), 32'(4'hC));
        ir_shift_cycles = 0; update_ir_cycles = 0;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("ir_exit1_tdo", 32'(bus16.tdo_en), 32'(1'b1));
        step(1'b1, 1'b0);
        chk("ir_update_tdo", 32'(bus16.tdo_en), 32'(1'b0));
        chk("ir_count", 32'(bus16.shift_count), 32'd33);
        step(1'b0, 1'b0);
        chk("ir_shift_cycles", 32'(ir_shift_cycles), 32'd33);
        chk("update_ir_cycles", 32'(update_ir_cycles), 32'd1);

        // DR scan interrupted by Pause-DR; count holds and resumes.
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        chk("pause_exit1_count", 32'(bus16.shift_count), 32'd3);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("pause_hold", 32'(bus16.shift_count), 32'd3);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("exit2_resume", 32'(bus16.tap_state), 32'(4'h2));
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        chk("pause_total", 32'(bus16.shift_count), 32'd6);

        // Into Shift-IR, then five TMS=1 edges reach Test-Logic-Reset.
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        chk("in_shift_ir", 32'(bus16.tap_state), 32'(4'hA));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("five_ones_tlr", 32'(bus16.tlr_reset), 32'(1'b1));

        // TRST aborts a DR scan at count 5 without an Update-DR.
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("abort_pre_count", 32'(bus16.shift_count), 32'd5);
        update_dr_cycles = 0;
        step(1'b1, 1'b1);
        chk("abort_state", 32'(bus16.tap_state), 32'(4'hF));
        chk("abort_count", 32'(bus16.shift_count), 32'd0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("abort_no_update", 32'(update_dr_cycles), 32'd0);

        // Saturation: 20 shift edges on both counter widths.
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("sat_w4",  32'(bus4.shift_count),  32'd15);
        chk("sat_w16", 32'(bus16.shift_count), 32'd20);

        // Random TMS with occasional TRST.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
